// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-style control unit.
// States, supported opcodes and the legality check used by the decoder.
package riscv_ctrl_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned TMR_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OP_ALUI   = 7'h13;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OP_ALUR   = 7'h33;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;

    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_ALUI) || (op == OP_STORE) ||
               (op == OP_ALUR) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory handshake, datapath strobes and status bundle of the control unit.
// master = controller side, slave = datapath/memory/environment side.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    import riscv_ctrl_pkg::*;

    logic [INSTR_W-1:0] instr_in;
    logic               imem_ready;
    logic               dmem_ready;
    logic               branch_taken;
    logic               imem_req;
    logic               ir_write;
    logic               dmem_read;
    logic               dmem_write;
    logic               alu_src_imm;
    logic               reg_write;
    logic               mem_to_reg;
    logic               pc_write;
    logic               pc_src_branch;
    logic [STATE_W-1:0] state;
    logic               illegal;
    logic               fault;
    logic [CNT_W-1:0]   retire_count;

    modport master (
        input  instr_in, imem_ready, dmem_ready, branch_taken,
        output imem_req, ir_write, dmem_read, dmem_write, alu_src_imm,
               reg_write, mem_to_reg, pc_write, pc_src_branch,
               state, illegal, fault, retire_count
    );

    modport slave (
        output instr_in, imem_ready, dmem_ready, branch_taken,
        input  imem_req, ir_write, dmem_read, dmem_write, alu_src_imm,
               reg_write, mem_to_reg, pc_write, pc_src_branch,
               state, illegal, fault, retire_count
    );

endinterface

// File: rtl/multicycle_control_wait_timer.sv
// Counts consecutive not-ready cycles of a memory handshake.
// expired flags the TIMEOUT-th such cycle; a ready in that cycle wins.
module wait_timer
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    input  logic wait_en,
    input  logic ready,
    output logic expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wait_en && !ready) begin
            count <= count + TMR_W'(1);
        end
    end

    assign expired = wait_en && !ready && (count == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb sequencing, sticky error
// flags and a retired-instruction counter.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 sysclk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t             state;
    state_t             state_next;
    logic [OPC_W-1:0]   opcode;
    logic               illegal_q;
    logic               fault_q;
    logic [CNT_W-1:0]   retire_q;

    logic imem_req_c, ir_write_c, dmem_read_c, dmem_write_c, alu_src_imm_c;
    logic reg_write_c, mem_to_reg_c, pc_write_c, pc_src_branch_c;
    logic retire_c, set_illegal_c, set_fault_c;
    logic timer_wait_en, timer_ready, timer_clear, timer_expired;
    logic unused_instr_bits;

    assign unused_instr_bits = ^bus.instr_in[INSTR_W-1:OPC_W];

    // Handshake being timed is chosen by state alone, so no loop through the FSM.
    assign timer_wait_en = (state == ST_FETCH) || (state == ST_MEM);
    assign timer_ready   = (state == ST_MEM) ? bus.dmem_ready : bus.imem_ready;
    assign timer_clear   = (state_next != state) &&
                           ((state_next == ST_FETCH) || (state_next == ST_MEM));

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .sysclk  (sysclk),
        .reset   (reset),
        .clear   (timer_clear),
        .wait_en (timer_wait_en),
        .ready   (timer_ready),
        .expired (timer_expired)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        imem_req_c      = 1'b0;
        ir_write_c      = 1'b0;
        dmem_read_c     = 1'b0;
        dmem_write_c    = 1'b0;
        alu_src_imm_c   = 1'b0;
        reg_write_c     = 1'b0;
        mem_to_reg_c    = 1'b0;
        pc_write_c      = 1'b0;
        pc_src_branch_c = 1'b0;
        retire_c        = 1'b0;
        set_illegal_c   = 1'b0;
        set_fault_c     = 1'b0;

        case (state)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_write_c = 1'b1;
                    state_next = ST_DECODE;
                end else if (timer_expired) begin
                    set_fault_c = 1'b1;
                    state_next  = ST_FAULT;
                end
            end
            ST_DECODE: begin
                if (is_legal(opcode)) begin
                    state_next = ST_EXEC;
                end else begin
                    set_illegal_c = 1'b1;
                    pc_write_c    = 1'b1;
                    state_next    = ST_FETCH;
                end
            end
            ST_EXEC: begin
                alu_src_imm_c = (opcode == OP_LOAD) || (opcode == OP_ALUI) ||
                                (opcode == OP_STORE);
                if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    state_next = ST_MEM;
                end else if ((opcode == OP_ALUI) || (opcode == OP_ALUR)) begin
                    state_next = ST_WB;
                end else begin
                    pc_write_c      = 1'b1;
                    pc_src_branch_c = bus.branch_taken;
                    retire_c        = 1'b1;
                    state_next      = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_read_c  = (opcode == OP_LOAD);
                dmem_write_c = (opcode == OP_STORE);
                if (bus.dmem_ready) begin
                    if (opcode == OP_LOAD) begin
                        state_next = ST_WB;
                    end else begin
                        pc_write_c = 1'b1;
                        retire_c   = 1'b1;
                        state_next = ST_FETCH;
                    end
                end else if (timer_expired) begin
                    set_fault_c = 1'b1;
                    state_next  = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = (opcode == OP_LOAD);
                pc_write_c   = 1'b1;
                retire_c     = 1'b1;
                state_next   = ST_FETCH;
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Opcode capture, sticky flags and retire counter.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            opcode    <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            retire_q  <= '0;
        end else begin
            if (ir_write_c) begin
                opcode <= bus.instr_in[OPC_W-1:0];
            end
            if (set_illegal_c) begin
                illegal_q <= 1'b1;
            end
            if (set_fault_c) begin
                fault_q <= 1'b1;
            end
            if (retire_c) begin
                retire_q <= retire_q + CNT_W'(1);
            end
        end
    end

    // Strobes are forced low while reset is held; imem_req simply tracks FETCH.
    assign bus.imem_req      = imem_req_c;
    assign bus.ir_write      = ir_write_c      & ~reset;
    assign bus.dmem_read     = dmem_read_c     & ~reset;
    assign bus.dmem_write    = dmem_write_c    & ~reset;
    assign bus.alu_src_imm   = alu_src_imm_c   & ~reset;
    assign bus.reg_write     = reg_write_c     & ~reset;
    assign bus.mem_to_reg    = mem_to_reg_c    & ~reset;
    assign bus.pc_write      = pc_write_c      & ~reset;
    assign bus.pc_src_branch = pc_src_branch_c & ~reset;
    assign bus.state         = state;
    assign bus.illegal       = illegal_q;
    assign bus.fault         = fault_q;
    assign bus.retire_count  = retire_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of consecutive wait cycles on a memory handshake before a fault is raised; legal range 2..255.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 sysclk  in  1  sole clock; all state updates occur on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 instr_in  in  32  instruction word returned by instruction memory, valid when imem_ready=1.
REQ-006 imem_ready  in  1  instruction memory has data for the current imem_req.
REQ-007 dmem_ready  in  1  data memory has completed the current dmem_read/dmem_write.
REQ-008 branch_taken  in  1  ALU branch condition for the current instruction, sampled in EXEC.
REQ-009 imem_req  out  1  instruction fetch request.
REQ-010 ir_write  out  1  load the instruction register.
REQ-011 dmem_read, dmem_write  out  1 each  data memory strobes.
REQ-012 alu_src_imm  out  1  selects the immediate as ALU operand B.
REQ-013 reg_write, mem_to_reg  out  1 each  register-file write enable and writeback select (1 = memory data).
REQ-014 pc_write, pc_src_branch  out  1 each  PC update enable and PC source select (1 = PC+imm, 0 = PC+4).
REQ-015 state  out  3  current FSM state encoding.
REQ-016 illegal  out  1  sticky flag: an unsupported opcode was decoded.
REQ-017 fault  out  1  sticky flag: a handshake timeout occurred.
REQ-018 retire_count  out  CNT_W  number of retired instructions; wraps modulo 2^CNT_W.

Function
REQ-019 Supported opcodes: 0x03 (load), 0x13 (ALU-immediate), 0x23 (store), 0x33 (ALU-register), 0x63 (branch); every other value is illegal.
REQ-020 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
REQ-021 FETCH: imem_req=1 every cycle; in the cycle imem_ready=1, ir_write=1 (combinational), opcode register <= instr_in[6:0], next state DECODE.
REQ-022 DECODE lasts 1 cycle: legal opcode -> EXEC; illegal opcode -> illegal<=1, pc_write=1, pc_src_branch=0, next state FETCH, no retire.
REQ-023 EXEC: alu_src_imm=1 for 0x03, 0x13, 0x23; 0x03 and 0x23 -> MEM; 0x13 and 0x33 -> WB; 0x63 -> pc_write=1, pc_src_branch=branch_taken, retire, next state FETCH.
REQ-024 MEM: dmem_read=1 (0x03) or dmem_write=1 (0x23) held until dmem_ready=1; then 0x03 -> WB; 0x23 -> pc_write=1, retire, next state FETCH.
REQ-025 WB lasts 1 cycle: reg_write=1, mem_to_reg=(opcode==0x03), pc_write=1, pc_src_branch=0, retire, next state FETCH.
REQ-026 A retire increments retire_count by 1 on the same clock edge that leaves the retiring state.
REQ-027 Wait timer: cleared on entry to FETCH or MEM; increments in each wait cycle with ready=0. When ready=0 in the TIMEOUT-th consecutive wait cycle -> fault<=1, next state FAULT.
REQ-028 Ready=1 in the TIMEOUT-th cycle completes the handshake normally; ready takes priority over timeout.
REQ-029 FAULT: all strobes 0; the state is held until reset.
REQ-030 All strobes are decoded from the state and the opcode register; they are 0 in any state not listed above.

Reset
REQ-031 Reset forces state=FETCH, opcode register=0, wait timer=0, illegal=0, fault=0, retire_count=0, immediately and asynchronously, including mid-handshake.
REQ-032 While reset=1, all strobes are 0 except imem_req, which follows the FETCH state after reset deasserts.

Structure
REQ-033 Package riscv_ctrl_pkg holds the state encodings, the five opcode constants, and the 3-bit state type.
REQ-034 One sub-module, wait_timer (parameter TIMEOUT; inputs clear, wait_en, ready; output expired), implements REQ-027/REQ-028; the FSM and counter remain in multicycle_control.

Verification
REQ-035 addi 0x00500093, imem_ready=1 -> states 0,1,2,4 over 4 cycles; reg_write=1 and alu_src_imm=1 in their cycles; retire_count 0->1.
REQ-036 lw 0x0000A103, dmem_ready rises in the third MEM cycle -> 7 cycles from FETCH to FETCH; mem_to_reg=1 in WB; dmem_read held for 3 cycles.
REQ-037 beq 0x00208463 with branch_taken=1 -> pc_write=1 and pc_src_branch=1 in EXEC; return to FETCH after 3 cycles; retire_count +1.
REQ-038 Illegal instruction 0x0000007F -> illegal=1 after DECODE; pc_write=1 and pc_src_branch=0 in DECODE; retire_count unchanged; next fetch proceeds.
REQ-039 TIMEOUT=16, imem_ready held 0 -> fault=1 and state=7 after the 16th wait cycle; ready=1 on the 16th cycle instead -> no fault.
REQ-040 sw 0x00112023 with reset asserted in the second MEM cycle -> dmem_write drops to 0 without a clock edge; state=0; retire_count=0.
